// File: rtl/cp0_exception_unit_if.sv
// Commit-stage bus between the MEM stage and the CP0 exception unit.
interface cp0_exception_unit_if;
  logic        mem_valid_i;
  logic        mem_stall_i;
  logic [7:0]  mem_exc_i;
  logic [31:0] mem_pc_i;
  logic [31:0] mem_addr_i;
  logic        mem_in_delay_slot_i;
  logic [5:0]  ext_int_i;
  logic        cp0_we_i;
  logic [4:0]  cp0_waddr_i;
  logic [4:0]  cp0_raddr_i;
  logic [31:0] cp0_wdata_i;
  logic [31:0] cp0_rdata_o;
  logic        flush_o;
  logic [31:0] redirect_pc_o;
  logic [4:0]  exc_code_o;

  modport master (
    output mem_valid_i, mem_stall_i, mem_exc_i, mem_pc_i, mem_addr_i,
           mem_in_delay_slot_i, ext_int_i, cp0_we_i, cp0_waddr_i,
           cp0_raddr_i, cp0_wdata_i,
    input  cp0_rdata_o, flush_o, redirect_pc_o, exc_code_o
  );

  modport slave (
    input  mem_valid_i, mem_stall_i, mem_exc_i, mem_pc_i, mem_addr_i,
           mem_in_delay_slot_i, ext_int_i, cp0_we_i, cp0_waddr_i,
           cp0_raddr_i, cp0_wdata_i,
    output cp0_rdata_o, flush_o, redirect_pc_o, exc_code_o
  );
endinterface

// File: rtl/cp0_exception_unit.sv
// CP0 exception unit: prioritises MEM-stage exceptions and interrupts, maintains
// Status/Cause/EPC/BadVAddr/Count/Compare, drives flush/redirect and MFC0/MTC0.
module cp0_exception_unit (
  input  logic                 clk,
  input  logic                 rst,
  cp0_exception_unit_if.slave  cp0_if
);

  localparam int unsigned     XLEN       = 32;
  localparam logic [31:0]     EXC_VECTOR = 32'hBFC0_0380;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  logic            tick_q, tick_d;
  logic [XLEN-1:0] count_q, count_d;
  logic [XLEN-1:0] compare_q, compare_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] badvaddr_q, badvaddr_d;
  logic [7:0]      status_im_q, status_im_d;
  logic            status_exl_q, status_exl_d;
  logic            status_ie_q, status_ie_d;
  logic            cause_bd_q, cause_bd_d;
  logic            cause_ti_q, cause_ti_d;
  logic [7:0]      cause_ip_q, cause_ip_d;
  logic [4:0]      cause_exc_q, cause_exc_d;

  logic            take_c;
  logic            int_pending_c;
  logic            exc_take_c;
  logic            eret_take_c;
  logic            bad_if_c;
  logic            bad_data_c;
  logic [4:0]      code_c;
  logic [XLEN-1:0] status_word_c;
  logic [XLEN-1:0] cause_word_c;

  assign take_c        = cp0_if.mem_valid_i & ~cp0_if.mem_stall_i & ~rst;
  assign int_pending_c = (|(cause_ip_q & status_im_q)) & status_ie_q & ~status_exl_q;

  assign status_word_c = {9'd0, 1'b1, 6'd0, status_im_q, 6'd0, status_exl_q, status_ie_q};
  assign cause_word_c  = {cause_bd_q, cause_ti_q, 14'd0, cause_ip_q, 1'b0, cause_exc_q, 2'b00};

  // Highest-priority cause of the committing instruction; Eret only if nothing else.
  always_comb begin
    exc_take_c  = 1'b0;
    eret_take_c = 1'b0;
    bad_if_c    = 1'b0;
    bad_data_c  = 1'b0;
    code_c      = EXC_INT;
    if (take_c) begin
      if (int_pending_c) begin
        exc_take_c = 1'b1;
        code_c     = EXC_INT;
      end else if (cp0_if.mem_exc_i[7]) begin
        exc_take_c = 1'b1;
        code_c     = EXC_ADEL;
        bad_if_c   = 1'b1;
      end else if (cp0_if.mem_exc_i[6]) begin
        exc_take_c = 1'b1;
        code_c     = EXC_RI;
      end else if (cp0_if.mem_exc_i[5]) begin
        exc_take_c = 1'b1;
        code_c     = EXC_OV;
      end else if (cp0_if.mem_exc_i[4]) begin
        exc_take_c = 1'b1;
        code_c     = EXC_SYS;
      end else if (cp0_if.mem_exc_i[3]) begin
        exc_take_c = 1'b1;
        code_c     = EXC_BP;
      end else if (cp0_if.mem_exc_i[1]) begin
        exc_take_c = 1'b1;
        code_c     = EXC_ADEL;
        bad_data_c = 1'b1;
      end else if (cp0_if.mem_exc_i[0]) begin
        exc_take_c = 1'b1;
        code_c     = EXC_ADES;
        bad_data_c = 1'b1;
      end else if (cp0_if.mem_exc_i[2]) begin
        eret_take_c = 1'b1;
      end
    end
  end

  always_comb begin
    cp0_if.flush_o       = exc_take_c | eret_take_c;
    cp0_if.exc_code_o    = exc_take_c ? code_c : 5'd0;
    cp0_if.redirect_pc_o = exc_take_c  ? EXC_VECTOR :
                           eret_take_c ? epc_q      : '0;
  end

  // MFC0 read port, straight from the architectural registers.
  always_comb begin
    cp0_if.cp0_rdata_o = '0;
    case (cp0_if.cp0_raddr_i)
      REG_BADVADDR: cp0_if.cp0_rdata_o = badvaddr_q;
      REG_COUNT:    cp0_if.cp0_rdata_o = count_q;
      REG_COMPARE:  cp0_if.cp0_rdata_o = compare_q;
      REG_STATUS:   cp0_if.cp0_rdata_o = status_word_c;
      REG_CAUSE:    cp0_if.cp0_rdata_o = cause_word_c;
      REG_EPC:      cp0_if.cp0_rdata_o = epc_q;
      default:      cp0_if.cp0_rdata_o = '0;
    endcase
  end

  // Next-state: timer and IP sampling always run; exception/Eret beat MTC0.
  always_comb begin
    tick_d       = ~tick_q;
    count_d      = tick_q ? count_q + XLEN'(1) : count_q;
    compare_d    = compare_q;
    epc_d        = epc_q;
    badvaddr_d   = badvaddr_q;
    status_im_d  = status_im_q;
    status_exl_d = status_exl_q;
    status_ie_d  = status_ie_q;
    cause_bd_d   = cause_bd_q;
    cause_ti_d   = cause_ti_q | ((count_q == compare_q) & (compare_q != '0));
    cause_ip_d   = {cp0_if.ext_int_i[5] | cause_ti_q, cp0_if.ext_int_i[4:0], cause_ip_q[1:0]};
    cause_exc_d  = cause_exc_q;

    if (exc_take_c) begin
      status_exl_d = 1'b1;
      cause_exc_d  = code_c;
      if (!status_exl_q) begin
        epc_d      = cp0_if.mem_in_delay_slot_i ? cp0_if.mem_pc_i - XLEN'(4) : cp0_if.mem_pc_i;
        cause_bd_d = cp0_if.mem_in_delay_slot_i;
      end
      if (bad_if_c) begin
        badvaddr_d = cp0_if.mem_pc_i;
      end else if (bad_data_c) begin
        badvaddr_d = cp0_if.mem_addr_i;
      end
    end else if (eret_take_c) begin
      status_exl_d = 1'b0;
    end else if (cp0_if.cp0_we_i) begin
      case (cp0_if.cp0_waddr_i)
        REG_COUNT:   count_d = cp0_if.cp0_wdata_i;
        REG_COMPARE: begin
          compare_d  = cp0_if.cp0_wdata_i;
          cause_ti_d = 1'b0;
        end
        REG_STATUS: begin
          status_im_d  = cp0_if.cp0_wdata_i[15:8];
          status_exl_d = cp0_if.cp0_wdata_i[1];
          status_ie_d  = cp0_if.cp0_wdata_i[0];
        end
        REG_CAUSE:   cause_ip_d[1:0] = cp0_if.cp0_wdata_i[9:8];
        REG_EPC:     epc_d = cp0_if.cp0_wdata_i;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q       <= 1'b0;
      count_q      <= '0;
      compare_q    <= '0;
      epc_q        <= '0;
      badvaddr_q   <= '0;
      status_im_q  <= '0;
      status_exl_q <= 1'b0;
      status_ie_q  <= 1'b0;
      cause_bd_q   <= 1'b0;
      cause_ti_q   <= 1'b0;
      cause_ip_q   <= '0;
      cause_exc_q  <= '0;
    end else begin
      tick_q       <= tick_d;
      count_q      <= count_d;
      compare_q    <= compare_d;
      epc_q        <= epc_d;
      badvaddr_q   <= badvaddr_d;
      status_im_q  <= status_im_d;
      status_exl_q <= status_exl_d;
      status_ie_q  <= status_ie_d;
      cause_bd_q   <= cause_bd_d;
      cause_ti_q   <= cause_ti_d;
      cause_ip_q   <= cause_ip_d;
      cause_exc_q  <= cause_exc_d;
    end
  end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Bench for cp0_exception_unit: word-level CP0 model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_cp0_exception_unit;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic clk;
  logic rst;
  cp0_exception_unit_if bus();

  cp0_exception_unit dut (
    .clk    (clk),
    .rst    (rst),
    .cp0_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: CP0 registers as whole 32-bit words indexed by register number.
  logic [31:0] m_reg [32];
  logic        m_tick;

  int         pri_bit  [7] = '{7, 6, 5, 4, 3, 1, 0};
  logic [4:0] pri_code [7] = '{5'h04, 5'h0A, 5'h0C, 5'h08, 5'h09, 5'h04, 5'h05};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // kind: 0 none, 1 exception, 2 eret; src: -1 interrupt, else exc bit index
  task automatic resolve(output int kind, output logic [4:0] code, output int src);
    logic intp;
    kind = 0; code = 5'd0; src = -2;
    if (rst || !bus.mem_valid_i || bus.mem_stall_i) return;
    intp = (|(m_reg[13][15:8] & m_reg[12][15:8])) && m_reg[12][0] && !m_reg[12][1];
    if (intp) begin
      kind = 1; src = -1;
      return;
    end
    for (int i = 0; i < 7; i++) begin
      if (bus.mem_exc_i[pri_bit[i]]) begin
        kind = 1; code = pri_code[i]; src = pri_bit[i];
        return;
      end
    end
    if (bus.mem_exc_i[2]) kind = 2;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    m_reg[12] = 32'h0040_0000;
    m_tick = 1'b0;
  endtask

  task automatic model_update();
    logic [31:0] n [32];
    int kind; logic [4:0] code; int src;
    if (rst) begin
      model_reset();
      return;
    end
    resolve(kind, code, src);
    n = m_reg;
    if (m_tick) n[9] = m_reg[9] + 32'd1;
    if (m_reg[9] == m_reg[11] && m_reg[11] != 32'd0) n[13][30] = 1'b1;
    n[13][15:10] = {bus.ext_int_i[5] | m_reg[13][30], bus.ext_int_i[4:0]};
    if (kind == 1) begin
      n[12][1]   = 1'b1;
      n[13][6:2] = code;
      if (!m_reg[12][1]) begin
        n[14]     = bus.mem_in_delay_slot_i ? bus.mem_pc_i - 32'd4 : bus.mem_pc_i;
        n[13][31] = bus.mem_in_delay_slot_i;
      end
      if (src == 7) n[8] = bus.mem_pc_i;
      if (src == 1 || src == 0) n[8] = bus.mem_addr_i;
    end else if (kind == 2) begin
      n[12][1] = 1'b0;
    end else if (bus.cp0_we_i) begin
      case (bus.cp0_waddr_i)
        5'd9:  n[9] = bus.cp0_wdata_i;
        5'd11: begin n[11] = bus.cp0_wdata_i; n[13][30] = 1'b0; end
        5'd12: n[12] = (n[12] & ~32'h0000_FF03) | (bus.cp0_wdata_i & 32'h0000_FF03);
        5'd13: n[13] = (n[13] & ~32'h0000_0300) | (bus.cp0_wdata_i & 32'h0000_0300);
        5'd14: n[14] = bus.cp0_wdata_i;
        default: ;
      endcase
    end
    m_reg  = n;
    m_tick = ~m_tick;
  endtask

  task automatic model_check();
    int kind; logic [4:0] code; int src;
    resolve(kind, code, src);
    chk("flush", 32'(bus.flush_o), (kind != 0) ? 32'd1 : 32'd0);
    chk("exc_code", 32'(bus.exc_code_o), (kind == 1) ? 32'(code) : 32'd0);
    chk("redirect", bus.redirect_pc_o, (kind == 1) ? VEC : (kind == 2) ? m_reg[14] : 32'd0);
    chk("rdata", bus.cp0_rdata_o, m_reg[bus.cp0_raddr_i]);
  endtask

  task automatic settle();
    #2;
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.mem_valid_i = 1'b0; bus.mem_stall_i = 1'b0; bus.mem_exc_i = 8'd0;
    bus.mem_in_delay_slot_i = 1'b0; bus.ext_int_i = 6'd0; bus.cp0_we_i = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle();
    bus.cp0_we_i = 1'b1; bus.cp0_waddr_i = a; bus.cp0_wdata_i = d;
    settle(); advance();
    bus.cp0_we_i = 1'b0;
  endtask

  task automatic expect_reg(input logic [4:0] a, input logic [31:0] exp, input string name);
    idle();
    bus.cp0_raddr_i = a;
    settle();
    chk(name, bus.cp0_rdata_o, exp);
    advance();
  endtask

  task automatic instr(input logic [7:0] exc, input logic [31:0] pc,
                       input logic [31:0] addr, input logic ds, input logic stall);
    idle();
    bus.mem_valid_i = 1'b1; bus.mem_stall_i = stall; bus.mem_exc_i = exc;
    bus.mem_pc_i = pc; bus.mem_addr_i = addr; bus.mem_in_delay_slot_i = ds;
    settle();
  endtask

  initial begin
    int n_wait;
    bit saw;
    logic [4:0] sel_reg [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3, 5'd20};

    rst = 1'b1;
    idle();
    bus.mem_pc_i = 32'd0; bus.mem_addr_i = 32'd0;
    bus.cp0_waddr_i = 5'd0; bus.cp0_raddr_i = 5'd12; bus.cp0_wdata_i = 32'd0;
    @(posedge clk); model_update(); @(negedge clk);

    // Reset state
    settle();
    chk("rst_status", bus.cp0_rdata_o, 32'h0040_0000);
    chk("rst_flush", 32'(bus.flush_o), 32'd0);
    advance();
    rst = 1'b0;

    // Overflow
    instr(8'h20, 32'h8000_0100, 32'd0, 1'b0, 1'b0);
    chk("ov_flush", 32'(bus.flush_o), 32'd1);
    chk("ov_redirect", bus.redirect_pc_o, 32'hBFC0_0380);
    chk("ov_code", 32'(bus.exc_code_o), 32'h0C);
    advance();
    expect_reg(5'd14, 32'h8000_0100, "ov_epc");
    expect_reg(5'd13, 32'h0000_0030, "ov_cause");
    expect_reg(5'd12, 32'h0040_0002, "ov_status");

    // Delay-slot store fault
    mtc0(5'd12, 32'd0);
    instr(8'h01, 32'h8000_0204, 32'h0000_1003, 1'b1, 1'b0);
    chk("st_flush", 32'(bus.flush_o), 32'd1);
    chk("st_code", 32'(bus.exc_code_o), 32'h05);
    advance();
    expect_reg(5'd14, 32'h8000_0200, "st_epc");
    expect_reg(5'd13, 32'h8000_0014, "st_cause");
    expect_reg(5'd8, 32'h0000_1003, "st_badvaddr");

    // Nested exception with EXL already set keeps EPC and BD
    instr(8'h40, 32'h8000_0400, 32'd0, 1'b0, 1'b0);
    chk("ri_code", 32'(bus.exc_code_o), 32'h0A);
    advance();
    expect_reg(5'd14, 32'h8000_0200, "nest_epc");
    expect_reg(5'd13, 32'h8000_0028, "nest_cause");

    // Priority IF fault over RI, then same while stalled
    instr(8'hC0, 32'h8000_0500, 32'h0000_2222, 1'b0, 1'b0);
    chk("pri_code", 32'(bus.exc_code_o), 32'h04);
    advance();
    expect_reg(5'd8, 32'h8000_0500, "pri_badvaddr");
    instr(8'hC0, 32'h8000_0600, 32'h0000_3333, 1'b0, 1'b1);
    chk("stall_flush", 32'(bus.flush_o), 32'd0);
    chk("stall_redirect", bus.redirect_pc_o, 32'd0);
    advance();
    expect_reg(5'd8, 32'h8000_0500, "stall_badvaddr");
    expect_reg(5'd13, 32'h8000_0010, "stall_cause");

    // ERET with a simultaneous MTC0 that must be dropped
    mtc0(5'd14, 32'h8000_0300);
    instr(8'h04, 32'h8000_0800, 32'd0, 1'b0, 1'b0);
    bus.cp0_we_i = 1'b1; bus.cp0_waddr_i = 5'd14; bus.cp0_wdata_i = 32'hDEAD_BEEF;
    #1;
    chk("eret_flush", 32'(bus.flush_o), 32'd1);
    chk("eret_redirect", bus.redirect_pc_o, 32'h8000_0300);
    chk("eret_code", 32'(bus.exc_code_o), 32'd0);
    advance();
    expect_reg(5'd12, 32'h0040_0000, "eret_status");
    expect_reg(5'd14, 32'h8000_0300, "eret_epc");

    // Timer interrupt
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd9, 32'd0);
    mtc0(5'd11, 32'd10);
    n_wait = 0;
    saw = 1'b0;
    while (n_wait < 40) begin
      idle();
      bus.cp0_raddr_i = 5'd13;
      settle();
      if (bus.cp0_rdata_o[30]) begin
        saw = 1'b1;
        break;
      end
      advance();
      n_wait++;
    end
    chk("ti_set", 32'(saw), 32'd1);
    chk("ti_delay", (n_wait >= 15 && n_wait <= 24) ? 32'd1 : 32'd0, 32'd1);
    advance();
    instr(8'h00, 32'h8000_0700, 32'd0, 1'b0, 1'b0);
    chk("int_flush", 32'(bus.flush_o), 32'd1);
    chk("int_code", 32'(bus.exc_code_o), 32'd0);
    chk("int_redirect", bus.redirect_pc_o, VEC);
    advance();
    expect_reg(5'd14, 32'h8000_0700, "int_epc");
    expect_reg(5'd12, 32'h0040_8003, "int_status");
    mtc0(5'd11, 32'd0);
    idle();
    bus.cp0_raddr_i = 5'd13;
    settle();
    chk("ti_cleared", bus.cp0_rdata_o & 32'h4000_0000, 32'd0);
    advance();

    // Count wrap
    mtc0(5'd9, 32'hFFFF_FFFF);
    expect_reg(5'd9, 32'hFFFF_FFFF, "count_max");
    saw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      bus.cp0_raddr_i = 5'd9;
      settle();
      if (bus.cp0_rdata_o == 32'd0) saw = 1'b1;
      advance();
    end
    chk("count_wrap", 32'(saw), 32'd1);

    // Reset mid-run with EXL=1
    mtc0(5'd9, 32'd57);
    instr(8'h20, 32'h8000_0900, 32'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rstrun_flush", 32'(bus.flush_o), 32'd0);
    chk("rstrun_code", 32'(bus.exc_code_o), 32'd0);
    advance();
    rst = 1'b0;
    expect_reg(5'd9, 32'd0, "rstrun_count");
    expect_reg(5'd12, 32'h0040_0000, "rstrun_status");

    // Randomised traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.mem_valid_i = ($urandom_range(0, 9) < 7);
      bus.mem_stall_i = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 5))
        0:       bus.mem_exc_i = 8'($urandom);
        1, 2:    bus.mem_exc_i = 8'(1 << $urandom_range(0, 7));
        default: bus.mem_exc_i = 8'd0;
      endcase
      bus.mem_pc_i = 32'($urandom);
      bus.mem_addr_i = 32'($urandom);
      bus.mem_in_delay_slot_i = 1'($urandom_range(0, 1));
      bus.ext_int_i = ($urandom_range(0, 15) == 0) ? 6'($urandom) : 6'd0;
      bus.cp0_we_i = ($urandom_range(0, 3) == 0);
      bus.cp0_waddr_i = sel_reg[$urandom_range(0, 7)];
      bus.cp0_wdata_i = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : 32'($urandom);
      bus.cp0_raddr_i = sel_reg[$urandom_range(0, 7)];
      settle();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
